// File: rtl/queued_resource_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// queued_resource_arbiter_pkg
// Shared types and helpers for the FIFO-order resource arbiter.
//   arb_state_t      : controller states (IDLE, GRANT, TURN)
//   N_REQ_DEF        : default number of requesters
//   MAX_HOLD_DEF     : default maximum grant length (timeout build only)
//   onehot_from_id() : requester ID -> one-hot vector (truncate at call site)
// -----------------------------------------------------------------------------
package queued_resource_arbiter_pkg;

    localparam int N_REQ_DEF    = 4;
    localparam int MAX_HOLD_DEF = 16;
    localparam int ONEHOT_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    // Callers cast the result down to their own requester count.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot_from_id(input logic [ONEHOT_MAX_W-1:0] id);
        return ONEHOT_MAX_W'(1) << id;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// -----------------------------------------------------------------------------
// arb_id_fifo
// Circular queue of requester IDs, depth N_REQ, used by the arbiter to hold
// requesters in arrival order.
// Ports:
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_push, i_push_id: write i_push_id at the tail
//   i_pop            : discard the head entry (illegal while empty)
//   o_head_id        : head entry, forced to 0 while empty
//   o_count          : number of stored entries
//   o_empty          : queue holds no entries
// -----------------------------------------------------------------------------
module arb_id_fifo
    import queued_resource_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_push,
    input  logic [ID_W-1:0] i_push_id,
    input  logic            i_pop,
    output logic [ID_W-1:0] o_head_id,
    output logic [ID_W:0]   o_count,
    output logic            o_empty
);

    localparam logic [ID_W-1:0] LAST_PTR   = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]   FULL_COUNT = (ID_W + 1)'(N_REQ);

    logic [ID_W-1:0] r_mem [N_REQ];
    logic [ID_W-1:0] r_wr_ptr;
    logic [ID_W-1:0] r_rd_ptr;
    logic [ID_W:0]   r_count;
    logic            w_empty;

    assign w_empty = (r_count == '0);

    // NOTE: the storage array has no reset; a slot is only read after it has
    // been written, and the head output is masked while the queue is empty.
    always_ff @(posedge i_clock) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_id = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_empty   = w_empty;

    // Queue depth equals the requester count, so neither case can occur in a
    // correct controller.
    a_no_pop_empty: assert property (@(posedge i_clock) disable iff (i_reset)
        !(i_pop && w_empty));
    a_no_overflow: assert property (@(posedge i_clock) disable iff (i_reset)
        !(i_push && !i_pop && (r_count == FULL_COUNT)));

endmodule

// File: rtl/queued_resource_arbiter.sv
// -----------------------------------------------------------------------------
// queued_resource_arbiter
// FIFO-order arbiter sharing one resource between N_REQ requesters. New
// requesters enter a circular ID queue (lowest index first, one per cycle);
// the head gets a registered one-hot grant held until it drops its request,
// followed by one mandatory idle cycle before the next grant.
// Optional build macro ARB_TIMEOUT_EN: a grant still requested after MAX_HOLD
// cycles is revoked, o_timeout pulses and the holder is re-queued at the tail.
// Ports:
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_request        : level request per requester
//   o_grant          : registered one-hot grant, zero when the resource is free
//   o_busy           : OR of o_grant
//   o_queue_count    : queued requesters, excluding the current holder
//   o_head_id        : ID at the queue head (0 while the queue is empty)
//   o_timeout        : one-cycle pulse when the hold timer revokes a grant
// -----------------------------------------------------------------------------
module queued_resource_arbiter
    import queued_resource_arbiter_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int ID_W     = $clog2(N_REQ),
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [N_REQ-1:0] i_request,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_busy,
    output logic [ID_W:0]    o_queue_count,
    output logic [ID_W-1:0]  o_head_id,
    output logic             o_timeout
);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] w_grant_next;
    logic [N_REQ-1:0] r_queued;
    logic [N_REQ-1:0] w_queued_next;
    logic [ID_W-1:0]  r_holder;
    logic [ID_W-1:0]  w_holder_next;

    logic             w_enq_valid;
    logic [ID_W-1:0]  w_enq_id;
    logic             w_push;
    logic [ID_W-1:0]  w_push_id;
    logic             w_pop;
    logic [ID_W-1:0]  w_head_id;
    logic [ID_W:0]    w_fifo_count;
    logic             w_fifo_empty;
    logic             w_timeout_fire;

    arb_id_fifo #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_push    (w_push),
        .i_push_id (w_push_id),
        .i_pop     (w_pop),
        .o_head_id (w_head_id),
        .o_count   (w_fifo_count),
        .o_empty   (w_fifo_empty)
    );

    // Lowest-index new requester; scanning downwards lets the lowest win.
    always_comb begin
        w_enq_valid = 1'b0;
        w_enq_id    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_request[i] && !r_queued[i]) begin
                w_enq_valid = 1'b1;
                w_enq_id    = ID_W'(i);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_timeout;

    assign w_timeout_fire = (r_state == GRANT) && i_request[r_holder]
                         && (r_hold_cnt == HOLD_LAST);

    // Held at zero outside GRANT, so it reads zero on the first GRANT cycle.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout  <= w_timeout_fire;
            r_hold_cnt <= (r_state == GRANT) ? r_hold_cnt + 1'b1 : '0;
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_timeout_fire = 1'b0;
    assign o_timeout      = 1'b0;
`endif

    // The timer compare value MAX_HOLD-1 needs at least a two-cycle hold.
    a_hold_range: assert property (@(posedge i_clock) disable iff (i_reset)
        (MAX_HOLD >= 2) && (CNT_W >= 1));

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_grant_next  = r_grant;
        w_queued_next = r_queued;
        w_holder_next = r_holder;
        w_pop         = 1'b0;
        w_push        = 1'b0;
        w_push_id     = w_enq_id;

        // A revoked holder takes the tail slot; the new requester waits a cycle.
        if (w_timeout_fire) begin
            w_push    = 1'b1;
            w_push_id = r_holder;
        end else if (w_enq_valid) begin
            w_push                  = 1'b1;
            w_queued_next[w_enq_id] = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (i_request[w_head_id]) begin
                        w_grant_next  = N_REQ'(onehot_from_id(32'(w_head_id)));
                        w_holder_next = w_head_id;
                        w_next_state  = GRANT;
                    end else begin
                        // Requester left while waiting: discard, no grant.
                        w_queued_next[w_head_id] = 1'b0;
                    end
                end
            end
            GRANT: begin
                if (!i_request[r_holder]) begin
                    w_grant_next            = '0;
                    w_queued_next[r_holder] = 1'b0;
                    w_next_state            = TURN;
                end else if (w_timeout_fire) begin
                    w_grant_next = '0;
                    w_next_state = TURN;
                end
            end
            TURN: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_grant  <= '0;
            r_queued <= '0;
            r_holder <= '0;
        end else begin
            r_grant  <= w_grant_next;
            r_queued <= w_queued_next;
            r_holder <= w_holder_next;
        end
    end

    assign o_grant       = r_grant;
    assign o_busy        = |r_grant;
    assign o_queue_count = w_fifo_count;
    assign o_head_id     = w_head_id;

endmodule

// File: doc/queued_resource_arbiter.md
Name: queued_resource_arbiter

Overview:
- Sequential FIFO-order arbiter that shares one resource between N_REQ requesters.
- Requests are queued by arrival order in a circular queue of requester IDs. The head of the queue receives a registered one-hot grant and holds it until it drops its request.
- Sits in front of the shared-resource datapath and drives its grant/select lines. Replaces the ad-hoc next-state logic around the CODA queue registers with a clean clocked controller.

Parameters:
- N_REQ, 4, number of requesters; queue depth equals N_REQ, so the queue can never overflow.
- ID_W, $clog2(N_REQ), width of a queued requester ID.
- MAX_HOLD, 16, maximum grant length in cycles; used only with ARB_TIMEOUT_EN.
- CNT_W, $clog2(MAX_HOLD+1), width of the hold counter.

Ports:
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- request  in  N_REQ  level request per requester; bit i belongs to requester i.
- grant  out  N_REQ  registered one-hot grant; all-zero when the resource is free.
- busy  out  1  high while any grant bit is set.
- queue_count  out  ID_W+1  number of queued (not yet granted) requesters.
- head_id  out  ID_W  ID at the queue head; valid only when queue_count != 0.
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold timer.

Behaviour:
- Reset (asynchronous, active-high):
  - grant=0, busy=0, queue_count=0, head_id=0, timeout=0.
  - Read/write pointers cleared, queued[] cleared, state=IDLE, hold counter cleared.
  - Reset mid-grant drops the grant at once; the queue contents are lost.
- queued[i] flag: set while requester i sits in the queue or holds the grant. It prevents double entry.
- Enqueue:
  - Each cycle, the lowest-index i with request[i]=1 and queued[i]=0 is written at the tail, and queued[i] is set.
  - Only one enqueue per cycle; other new requesters enter on later cycles in index order.
- Dequeued-while-waiting:
  - If a queued requester drops its request before being granted, its entry stays in the queue.
  - When that entry reaches the head, the pop skips it: the entry is discarded, queued[i] is cleared, and no grant is issued that cycle.
- FSM states: IDLE, GRANT, TURN.
  - IDLE, queue non-empty, head still requesting: pop the head, set grant[head]=1 next cycle, go to GRANT. Grant latency is 1 cycle after a request on an empty queue with the resource free, measured from enqueue, so 2 cycles from the request edge.
  - GRANT, request[holder]=0: clear grant and queued[holder] next cycle, go to TURN.
  - TURN: one mandatory idle cycle with grant=0, then go to IDLE. There is never back-to-back grant overlap, and at least one zero cycle separates grants.
- Simultaneous events:
  - Enqueue and pop in the same cycle are both performed; queue_count is unchanged.
  - A requester that releases and re-raises request during TURN is re-enqueued at the tail in TURN at the earliest.
- queue_count excludes the current grant holder.
- Pointer wrap-around is modulo N_REQ.
- busy is the OR of grant.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter equals MAX_HOLD-1 and request[holder] is still 1: grant is cleared next cycle, timeout pulses for 1 cycle, and the holder is pushed back at the tail with queued kept set. The push has priority over the normal enqueue that cycle. The FSM then goes to TURN.
- Undefined: no counter logic, timeout is tied to 0, and a grant is held indefinitely.

Decomposition:
- Package queued_resource_arbiter_pkg holds:
  - the FSM state enum (IDLE, GRANT, TURN);
  - default constants N_REQ_DEF=4 and MAX_HOLD_DEF=16;
  - the function onehot_from_id().
- One sub-module, arb_id_fifo:
  - circular ID queue with push/pop/count;
  - depth N_REQ;
  - write-first when a push and a pop share a cycle on an empty queue is not allowed: a pop on an empty queue is illegal and is asserted.

Test Plan:
1. request=4'b0001 from idle -> grant=0001 at cycle +2, busy=1. Drop request -> grant=0000 next cycle, TURN one cycle, queue_count=0.
2. request=4'b1111 in one cycle -> enqueue order 0,1,2,3. Grants are issued in order 0001, 0010, 0100, 1000 as each holder releases, each separated by a zero grant cycle. queue_count peaks at 3.
3. Holder 0 active, requester 2 raises then drops before reaching the head -> its entry is skipped and grant never shows 0100. queue_count returns to 0.
4. Holder 1 releases while requester 3 raises in the same cycle -> requester 3 enqueued; grant=1000 after TURN; queue_count is never inconsistent.
5. With ARB_TIMEOUT_EN and MAX_HOLD=4: requester 0 holds while requester 1 waits -> timeout=1 in the cycle after 4 GRANT cycles, grant=0010 after TURN, requester 0 re-queued (queue_count=1). Without the macro -> grant=0001 held for 100 cycles, timeout=0.
6. reset asserted asynchronously mid-GRANT with 2 entries queued -> grant=0, queue_count=0, timeout=0 immediately. After deassert with requests held, arbitration restarts from index 0.
